memory_subcycle_sequencer: RTL and testbench
============================================

MEMORY_SUBCYCLE_SEQUENCER -- requirements
Module: memory_subcycle_sequencer

Interface
REQ-001 SHALL have parameter NUM_LANES, default 16 (`VECTOR_LANES), number of vector lanes per request.
REQ-002 SHALL have ports `clk` (in, 1) as the single clock and `reset` (in, 1) as the asynchronous, active-low reset.
REQ-003 SHALL have request ports from issue:
- req_valid, in, 1
- req_ready, out, 1
- req_thread_idx, in, thread_idx_t
- req_access_type, in, memory_access_type enum
- req_mask, in, NUM_LANES
- req_base_addr, in, scalar_t
- req_stride, in, scalar_t
- req_lane_addr, in, vector_t (per-lane scatter/gather pointers)
REQ-004 SHALL have beat ports to the dcache tag stage:
- seq_valid, out, 1
- seq_ready, in, 1
- seq_thread_idx, out, thread_idx_t
- seq_subcycle, out, subcycle_t
- seq_addr, out, scalar_t
- seq_lane_en, out, 1
- seq_last, out, 1
REQ-005 SHALL have rollback inputs from writeback: wb_rollback_en (1), wb_rollback_thread_idx (thread_idx_t), wb_rollback_pipeline (pipeline_sel_t).

Function
REQ-006 SHALL implement two states, IDLE and SEQ; a request is accepted when req_valid && req_ready.
REQ-007 SHALL classify each request: MEM_SCGATH* and MEM_STRIDED* are multi-beat; all other access types are single-beat.
REQ-008 SHALL drive req_ready = (state==IDLE) || (seq_valid && seq_ready && seq_last).
REQ-009 SHALL emit the first beat registered, one cycle after acceptance; outputs are flops, with no combinational path from req_* to seq_*.
REQ-010 Single-beat requests SHALL produce exactly one beat:
- seq_subcycle=0, seq_addr=req_base_addr, seq_lane_en=1, seq_last=1.
REQ-011 Multi-beat requests SHALL emit one beat per set bit of req_mask, in ascending lane order.
- Cleared lanes are skipped with no idle cycles.
- seq_subcycle=lane index; seq_lane_en=1.
REQ-012 Strided address SHALL be req_base_addr + lane*req_stride, computed modulo 2^32 (wrap, no overflow flag).
REQ-013 Scatter/gather address SHALL be req_lane_addr[lane].
REQ-014 seq_last SHALL be 1 on the beat for the highest set mask bit.
REQ-015 A multi-beat request with req_mask==0 SHALL emit a single beat: seq_subcycle=0, seq_lane_en=0, seq_last=1.
REQ-016 While seq_valid && !seq_ready, all seq_* outputs SHALL hold stable.
REQ-017 The current beat SHALL advance only on seq_ready.
REQ-018 After the last beat is accepted with no new request pending, the block SHALL return to IDLE and seq_valid=0 the next cycle.
REQ-019 Back-to-back requests SHALL issue with no bubble: a request accepted on the last-beat handshake produces its first beat in the next cycle.
REQ-020 Rollback match = wb_rollback_en && wb_rollback_pipeline==PIPE_MEM && wb_rollback_thread_idx==seq_thread_idx.
- A match in SEQ SHALL set seq_valid=0 and state=IDLE next cycle, regardless of seq_ready.
REQ-021 A rollback matching req_thread_idx in the acceptance cycle SHALL discard that request: no beats are emitted.
REQ-022 A rollback for another thread or pipeline SHALL have no effect.
REQ-023 Request fields SHALL be latched at acceptance; req_* changes afterwards do not affect an in-flight request.

Reset
REQ-024 While reset is low, outputs SHALL be:
- state=IDLE, seq_valid=0, seq_last=0, seq_lane_en=0
- seq_subcycle=0, seq_addr=0, seq_thread_idx=0
- req_ready=1 (IDLE)
REQ-025 Reset asserted mid-sequence SHALL abandon the request immediately (asynchronous); no beat is emitted after reset deasserts until a new request is accepted.

Structure
REQ-026 thread_idx_t, scalar_t, vector_t, subcycle_t, pipeline_sel_t and the memory_access_type enum SHALL come from the shared defines package; no local redefinitions.
REQ-027 Next-lane selection (lowest set bit of the remaining mask, plus a none-left flag) SHALL be a sub-module, lane_priority_encoder, parameterised by NUM_LANES.
REQ-028 The remaining-mask register SHALL clear each lane's bit as its beat is accepted.

Verification
REQ-029 Scalar MEM_L, base 0x1000 -> one beat next cycle: subcycle 0, addr 0x1000, last=1; req_ready=1 on the same cycle.
REQ-030 MEM_STRIDED, base 0xFFFFFFF0, stride 8, mask 0x0005 -> two beats:
- addr 0xFFFFFFF0, subcycle 0
- addr 0x00000000, subcycle 2, last=1
REQ-031 MEM_SCGATH, mask 0x8001, seq_ready low for 3 cycles on beat 1:
- outputs stable while stalled
- beats at subcycle 0 and subcycle 15, last only on 15.
REQ-032 MEM_SCGATH, mask 0 -> one beat: lane_en=0, last=1.
REQ-033 MEM_SCGATH mask 0xFFFF on thread 2, rollback (PIPE_MEM, thread 2) after beat 4 -> seq_valid=0 next cycle; IDLE. The same rollback targeting thread 1 -> all 16 beats emitted.
REQ-034 Reset pulsed low mid-sequence -> seq_valid=0 immediately, req_ready=1; the next request is sequenced from subcycle 0.

Source files
------------

// File: rtl/memory_subcycle_sequencer_pkg.sv
// Shared defines for the vector memory path: lane/thread/address types and access kinds.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package memory_subcycle_sequencer_pkg;

   localparam int VECTOR_LANES = 16;
   localparam int THREAD_IDX_W = 2;

   typedef logic [THREAD_IDX_W-1:0]          thread_idx_t;
   typedef logic [31:0]                      scalar_t;
   typedef scalar_t [VECTOR_LANES-1:0]       vector_t;
   typedef logic [$clog2(VECTOR_LANES)-1:0]  subcycle_t;

   typedef enum logic [1:0] {
      PIPE_MEM,
      PIPE_INT,
      PIPE_FP,
      PIPE_SFU
   } pipeline_sel_t;

   typedef enum logic [3:0] {
      MEM_B,
      MEM_BX,
      MEM_S,
      MEM_SX,
      MEM_L,
      MEM_SYNC,
      MEM_FLUSH,
      MEM_STRIDED,
      MEM_STRIDED_M,
      MEM_SCGATH,
      MEM_SCGATH_M
   } memory_access_type;

   typedef enum logic {
      ST_IDLE,
      ST_SEQ
   } seq_state_t;

   function automatic logic is_scgath(input memory_access_type t);
      return (t == MEM_SCGATH) || (t == MEM_SCGATH_M);
   endfunction

   function automatic logic is_strided(input memory_access_type t);
      return (t == MEM_STRIDED) || (t == MEM_STRIDED_M);
   endfunction

   // Strided and scatter/gather walk the lane mask; everything else is one beat.
   function automatic logic is_multi_beat(input memory_access_type t);
      return is_scgath(t) || is_strided(t);
   endfunction

endpackage

// File: rtl/lane_priority_encoder.sv
// Picks the lowest set lane of a mask and flags an empty mask.
// Latency: purely combinational.
// Backpressure: none (no state, no handshake).
// Ports: mask_i  - lanes still to visit
//        idx_o   - index of lowest set bit (0 when mask is empty)
//        none_o  - 1 when no bit is set
module lane_priority_encoder #(
   parameter int NUM_LANES = 16
) (
   input  logic [NUM_LANES-1:0]         mask_i,
   output logic [$clog2(NUM_LANES)-1:0] idx_o,
   output logic                         none_o
);

   always_comb begin
      idx_o  = '0;
      none_o = 1'b1;
      // Scan high to low so the last hit written is the lowest set lane.
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            idx_o  = ($clog2(NUM_LANES))'(i);
            none_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/memory_subcycle_sequencer.sv
// Splits a vector memory request into per-lane beats for the dcache tag stage.
// Latency: first beat registered one cycle after acceptance; next request chains on the last-beat handshake.
// Backpressure: beats hold while seq_ready is low; req_ready only in IDLE or on the last-beat handshake.
// Ports: clk/reset (async active-low); req_* issue-side request (valid/ready);
//        seq_* per-lane beat to dcache (valid/ready); wb_rollback_* squash from writeback.
module memory_subcycle_sequencer
   import memory_subcycle_sequencer_pkg::*;
#(
   parameter int NUM_LANES = VECTOR_LANES
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  thread_idx_t           req_thread_idx,
   input  memory_access_type     req_access_type,
   input  logic [NUM_LANES-1:0]  req_mask,
   input  scalar_t               req_base_addr,
   input  scalar_t               req_stride,
   input  vector_t               req_lane_addr,
   output logic                  seq_valid,
   input  logic                  seq_ready,
   output thread_idx_t           seq_thread_idx,
   output subcycle_t             seq_subcycle,
   output scalar_t               seq_addr,
   output logic                  seq_lane_en,
   output logic                  seq_last,
   input  logic                  wb_rollback_en,
   input  thread_idx_t           wb_rollback_thread_idx,
   input  pipeline_sel_t         wb_rollback_pipeline
);

   localparam int LIDX_W = $clog2(NUM_LANES);

   seq_state_t           state_q, state_d;
   logic                 seq_valid_q, seq_valid_d;
   logic                 seq_last_q, seq_last_d;
   logic                 seq_lane_en_q, seq_lane_en_d;
   subcycle_t            seq_subcycle_q, seq_subcycle_d;
   scalar_t              seq_addr_q, seq_addr_d;
   thread_idx_t          seq_thread_idx_q, seq_thread_idx_d;
   memory_access_type    type_q, type_d;
   scalar_t              base_q, base_d;
   scalar_t              stride_q, stride_d;
   vector_t              lane_addr_q, lane_addr_d;
   // Lanes still to emit after the beat currently presented.
   logic [NUM_LANES-1:0] mask_rem_q, mask_rem_d;

   logic advance, accept, req_kill, load, seq_kill;

   assign advance   = seq_valid_q && seq_ready;
   assign req_ready = (state_q == ST_IDLE) || (advance && seq_last_q);
   assign accept    = req_valid && req_ready;
   assign req_kill  = wb_rollback_en && (wb_rollback_pipeline == PIPE_MEM) &&
                      (wb_rollback_thread_idx == req_thread_idx);
   assign load      = accept && !req_kill;
   assign seq_kill  = (state_q == ST_SEQ) && wb_rollback_en &&
                      (wb_rollback_pipeline == PIPE_MEM) &&
                      (wb_rollback_thread_idx == seq_thread_idx_q);

   // On acceptance the first beat is built straight from the request so it can
   // be registered without a bubble; otherwise from the latched copy.
   memory_access_type    src_type;
   logic [NUM_LANES-1:0] src_mask;
   scalar_t              src_base, src_stride;
   vector_t              src_lane_addr;

   assign src_type      = load ? req_access_type : type_q;
   assign src_mask      = load ? req_mask        : mask_rem_q;
   assign src_base      = load ? req_base_addr   : base_q;
   assign src_stride    = load ? req_stride      : stride_q;
   assign src_lane_addr = load ? req_lane_addr   : lane_addr_q;

   logic [LIDX_W-1:0] lane_idx;
   logic              lane_none;

   lane_priority_encoder #(.NUM_LANES(NUM_LANES)) u_lane_pe (
      .mask_i (src_mask),
      .idx_o  (lane_idx),
      .none_o (lane_none)
   );

   subcycle_t            beat_subcycle;
   scalar_t              beat_addr;
   logic                 beat_lane_en, beat_last;
   logic [NUM_LANES-1:0] beat_mask_after;

   always_comb begin
      beat_subcycle   = '0;
      beat_addr       = src_base;
      beat_lane_en    = 1'b1;
      beat_last       = 1'b1;
      beat_mask_after = '0;
      if (is_multi_beat(src_type)) begin
         // An empty mask still yields one disabled beat so the request retires.
         beat_mask_after = src_mask & ~(NUM_LANES'(1) << lane_idx);
         beat_subcycle   = subcycle_t'(lane_idx);
         beat_lane_en    = !lane_none;
         beat_last       = ~|beat_mask_after;
         if (is_scgath(src_type)) begin
            beat_addr = src_lane_addr[lane_idx];
         end else begin
            beat_addr = src_base + src_stride * scalar_t'(lane_idx);
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      seq_valid_d      = seq_valid_q;
      seq_last_d       = seq_last_q;
      seq_lane_en_d    = seq_lane_en_q;
      seq_subcycle_d   = seq_subcycle_q;
      seq_addr_d       = seq_addr_q;
      seq_thread_idx_d = seq_thread_idx_q;
      type_d           = type_q;
      base_d           = base_q;
      stride_d         = stride_q;
      lane_addr_d      = lane_addr_q;
      mask_rem_d       = mask_rem_q;

      if (load) begin
         state_d          = ST_SEQ;
         seq_valid_d      = 1'b1;
         seq_thread_idx_d = req_thread_idx;
         type_d           = req_access_type;
         base_d           = req_base_addr;
         stride_d         = req_stride;
         lane_addr_d      = req_lane_addr;
         seq_subcycle_d   = beat_subcycle;
         seq_addr_d       = beat_addr;
         seq_lane_en_d    = beat_lane_en;
         seq_last_d       = beat_last;
         mask_rem_d       = beat_mask_after;
      end else if (seq_kill || (advance && seq_last_q)) begin
         // Rollback squashes the in-flight request even if the beat is being taken.
         state_d     = ST_IDLE;
         seq_valid_d = 1'b0;
      end else if (advance) begin
         seq_subcycle_d = beat_subcycle;
         seq_addr_d     = beat_addr;
         seq_lane_en_d  = beat_lane_en;
         seq_last_d     = beat_last;
         mask_rem_d     = beat_mask_after;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= ST_IDLE;
         seq_valid_q      <= 1'b0;
         seq_last_q       <= 1'b0;
         seq_lane_en_q    <= 1'b0;
         seq_subcycle_q   <= '0;
         seq_addr_q       <= '0;
         seq_thread_idx_q <= '0;
         type_q           <= MEM_B;
         base_q           <= '0;
         stride_q         <= '0;
         lane_addr_q      <= '0;
         mask_rem_q       <= '0;
      end else begin
         state_q          <= state_d;
         seq_valid_q      <= seq_valid_d;
         seq_last_q       <= seq_last_d;
         seq_lane_en_q    <= seq_lane_en_d;
         seq_subcycle_q   <= seq_subcycle_d;
         seq_addr_q       <= seq_addr_d;
         seq_thread_idx_q <= seq_thread_idx_d;
         type_q           <= type_d;
         base_q           <= base_d;
         stride_q         <= stride_d;
         lane_addr_q      <= lane_addr_d;
         mask_rem_q       <= mask_rem_d;
      end
   end

   assign seq_valid      = seq_valid_q;
   assign seq_last       = seq_last_q;
   assign seq_lane_en    = seq_lane_en_q;
   assign seq_subcycle   = seq_subcycle_q;
   assign seq_addr       = seq_addr_q;
   assign seq_thread_idx = seq_thread_idx_q;

endmodule

// File: tb/tb_memory_subcycle_sequencer.sv
// Bench for memory_subcycle_sequencer: directed requests with hand-computed beats.
// Expected beats are queued at issue; a monitor pops and compares on each handshake.
// Also checks reset values, stall stability, rollback and mid-sequence reset.
module tb_memory_subcycle_sequencer;
   import memory_subcycle_sequencer_pkg::*;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   thread_idx_t       req_thread_idx = '0;
   memory_access_type req_access_type = MEM_B;
   logic [15:0]       req_mask = '0;
   scalar_t           req_base_addr = '0;
   scalar_t           req_stride = '0;
   vector_t           req_lane_addr = '0;
   logic              seq_valid;
   logic              seq_ready = 1'b1;
   thread_idx_t       seq_thread_idx;
   subcycle_t         seq_subcycle;
   scalar_t           seq_addr;
   logic              seq_lane_en;
   logic              seq_last;
   logic              wb_rollback_en = 1'b0;
   thread_idx_t       wb_rollback_thread_idx = '0;
   pipeline_sel_t     wb_rollback_pipeline = PIPE_MEM;

   memory_subcycle_sequencer #(.NUM_LANES(16)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_thread_idx(req_thread_idx), .req_access_type(req_access_type),
      .req_mask(req_mask), .req_base_addr(req_base_addr),
      .req_stride(req_stride), .req_lane_addr(req_lane_addr),
      .seq_valid(seq_valid), .seq_ready(seq_ready),
      .seq_thread_idx(seq_thread_idx), .seq_subcycle(seq_subcycle),
      .seq_addr(seq_addr), .seq_lane_en(seq_lane_en), .seq_last(seq_last),
      .wb_rollback_en(wb_rollback_en), .wb_rollback_thread_idx(wb_rollback_thread_idx),
      .wb_rollback_pipeline(wb_rollback_pipeline)
   );

   always #5 clk = ~clk;

   typedef struct {
      thread_idx_t thr;
      subcycle_t   sc;
      scalar_t     addr;
      logic        chk_addr;
      logic        en;
      logic        last;
   } beat_t;

   beat_t   exp_q[$];
   int      checks = 0;
   int      failures = 0;
   int      beats_seen = 0;
   vector_t lane_tab;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic push(input thread_idx_t thr, input int sc, input scalar_t addr,
                       input logic chk_addr, input logic en, input logic last);
      beat_t b;
      b.thr = thr; b.sc = subcycle_t'(sc); b.addr = addr;
      b.chk_addr = chk_addr; b.en = en; b.last = last;
      exp_q.push_back(b);
   endtask

   // Full-mask scatter/gather expectation: lane i reads lane_tab[i].
   task automatic push_scg_full(input thread_idx_t thr);
      for (int i = 0; i < 16; i++) push(thr, i, lane_tab[i], 1'b1, 1'b1, i == 15);
   endtask

   // Monitor: compares every accepted beat and the hold of stalled beats.
   logic        stall_prev = 1'b0;
   thread_idx_t snap_thr;
   subcycle_t   snap_sc;
   scalar_t     snap_addr;
   logic        snap_en, snap_last;

   always @(negedge clk) begin
      beat_t e;
      if (seq_valid && stall_prev) begin
         check("stall_hold", {seq_thread_idx, seq_subcycle, seq_lane_en, seq_last, seq_addr[23:0]},
               {snap_thr, snap_sc, snap_en, snap_last, snap_addr[23:0]});
      end
      if (seq_valid && seq_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat actual sc=%0d addr=0x%08h expected none", seq_subcycle, seq_addr);
         end else begin
            e = exp_q.pop_front();
            if (seq_thread_idx !== e.thr || seq_subcycle !== e.sc || seq_lane_en !== e.en ||
                seq_last !== e.last || (e.chk_addr && seq_addr !== e.addr)) begin
               failures++;
               $display("FAIL beat actual thr=%0d sc=%0d addr=0x%08h en=%0b last=%0b expected thr=%0d sc=%0d addr=0x%08h en=%0b last=%0b",
                        seq_thread_idx, seq_subcycle, seq_addr, seq_lane_en, seq_last,
                        e.thr, e.sc, e.addr, e.en, e.last);
            end
         end
         beats_seen++;
      end
      stall_prev = seq_valid && !seq_ready;
      snap_thr = seq_thread_idx; snap_sc = seq_subcycle; snap_addr = seq_addr;
      snap_en = seq_lane_en; snap_last = seq_last;
   end

   // Presents a request until accepted; afterwards scrambles req_* to prove latching.
   task automatic send_req(input thread_idx_t thr, input memory_access_type t, input logic [15:0] mask,
                           input scalar_t base, input scalar_t stride, input logic kill);
      int  n = 0;
      bit  done = 0;
      req_valid = 1'b1; req_thread_idx = thr; req_access_type = t; req_mask = mask;
      req_base_addr = base; req_stride = stride; req_lane_addr = lane_tab;
      if (kill) begin
         wb_rollback_en = 1'b1; wb_rollback_thread_idx = thr; wb_rollback_pipeline = PIPE_MEM;
      end
      while (!done && n < 200) begin
         @(negedge clk);
         if (req_ready) done = 1;
         n++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0; req_base_addr = 32'hDEAD_BEEF; req_stride = 32'h5555_5555;
      req_mask = 16'hA5A5; req_access_type = MEM_SCGATH; req_lane_addr = '1;
      wb_rollback_en = 1'b0;
      if (!done) begin
         checks++; failures++;
         $display("FAIL req_accept_timeout actual=not_accepted expected=accepted");
      end
   endtask

   task automatic wait_beats(input int start, input int n);
      int k = 0;
      while (beats_seen < start + n && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      if (beats_seen < start + n) begin
         checks++; failures++;
         $display("FAIL beat_wait_timeout actual=%0d expected=%0d", beats_seen - start, n);
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || seq_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++; failures++;
         $display("FAIL drain_timeout actual=%0d_pending expected=0", exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int start;
      for (int i = 0; i < 16; i++) lane_tab[i] = 32'hA000_0000 + 32'(i) * 32'h100;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_seq_valid", 32'(seq_valid), 32'd0);
      check("rst_seq_last", 32'(seq_last), 32'd0);
      check("rst_seq_lane_en", 32'(seq_lane_en), 32'd0);
      check("rst_seq_subcycle", 32'(seq_subcycle), 32'd0);
      check("rst_seq_addr", seq_addr, 32'd0);
      check("rst_seq_thread", 32'(seq_thread_idx), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // Scalar load: one beat next cycle, ready again on that cycle
      push(2'd1, 0, 32'h0000_1000, 1'b1, 1'b1, 1'b1);
      send_req(2'd1, MEM_L, 16'hFFFF, 32'h0000_1000, 32'h4, 1'b0);
      @(negedge clk);
      check("scalar_valid", 32'(seq_valid), 32'd1);
      check("scalar_req_ready", 32'(req_ready), 32'd1);
      wait_drain();
      check("idle_after_last", 32'(seq_valid), 32'd0);

      // Strided with address wrap
      push(2'd0, 0, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0);
      push(2'd0, 2, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
      send_req(2'd0, MEM_STRIDED, 16'h0005, 32'hFFFF_FFF0, 32'h8, 1'b0);
      wait_drain();

      // Scatter/gather with first beat stalled 3 cycles
      seq_ready = 1'b0;
      push(2'd3, 0, 32'hA000_0000, 1'b1, 1'b1, 1'b0);
      push(2'd3, 15, 32'hA000_0F00, 1'b1, 1'b1, 1'b1);
      send_req(2'd3, MEM_SCGATH, 16'h8001, 32'h0, 32'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1 seq_ready = 1'b1;
      wait_drain();

      // Empty mask: one disabled last beat
      push(2'd2, 0, 32'h0, 1'b0, 1'b0, 1'b1);
      send_req(2'd2, MEM_SCGATH, 16'h0000, 32'h0000_3000, 32'h0, 1'b0);
      wait_drain();

      // Rollback of thread 2 after 4 beats
      for (int i = 0; i < 4; i++) push(2'd2, i, lane_tab[i], 1'b1, 1'b1, 1'b0);
      start = beats_seen;
      send_req(2'd2, MEM_SCGATH, 16'hFFFF, 32'h0, 32'h0, 1'b0);
      wait_beats(start, 4);
      seq_ready = 1'b0;
      wb_rollback_en = 1'b1; wb_rollback_thread_idx = 2'd2; wb_rollback_pipeline = PIPE_MEM;
      @(posedge clk); #1;
      wb_rollback_en = 1'b0;
      @(negedge clk);
      check("rollback_valid_drop", 32'(seq_valid), 32'd0);
      check("rollback_idle_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      seq_ready = 1'b1;
      wait_drain();
      check("rollback_pending", 32'(exp_q.size()), 32'd0);

      // Rollbacks for another thread / another pipeline: full 16 beats
      push_scg_full(2'd2);
      start = beats_seen;
      send_req(2'd2, MEM_SCGATH, 16'hFFFF, 32'h0, 32'h0, 1'b0);
      wait_beats(start, 4);
      wb_rollback_en = 1'b1; wb_rollback_thread_idx = 2'd1; wb_rollback_pipeline = PIPE_MEM;
      @(posedge clk); #1;
      wb_rollback_thread_idx = 2'd2; wb_rollback_pipeline = PIPE_INT;
      @(posedge clk); #1;
      wb_rollback_en = 1'b0; wb_rollback_pipeline = PIPE_MEM;
      wait_drain();
      check("other_rb_beats", 32'(beats_seen - start), 32'd16);

      // Rollback in the acceptance cycle discards the request
      send_req(2'd3, MEM_STRIDED, 16'h00FF, 32'h100, 32'h4, 1'b1);
      repeat (2) @(negedge clk);
      check("discard_no_beat", 32'(seq_valid), 32'd0);
      @(posedge clk); #1;

      // Back-to-back: second request accepted on last handshake, no bubble
      push(2'd1, 0, 32'h0000_2000, 1'b1, 1'b1, 1'b0);
      push(2'd1, 1, 32'h0000_2010, 1'b1, 1'b1, 1'b1);
      send_req(2'd1, MEM_STRIDED_M, 16'h0003, 32'h0000_2000, 32'h10, 1'b0);
      push(2'd0, 4, 32'hA000_0400, 1'b1, 1'b1, 1'b1);
      send_req(2'd0, MEM_SCGATH_M, 16'h0010, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      check("b2b_valid", 32'(seq_valid), 32'd1);
      check("b2b_subcycle", 32'(seq_subcycle), 32'd4);
      wait_drain();

      // Reset mid-sequence
      push_scg_full(2'd0);
      start = beats_seen;
      send_req(2'd0, MEM_SCGATH, 16'hFFFF, 32'h0, 32'h0, 1'b0);
      wait_beats(start, 3);
      reset = 1'b0;
      #1;
      check("midrst_valid", 32'(seq_valid), 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("postrst_no_beat", 32'(seq_valid), 32'd0);
      @(posedge clk); #1;
      push(2'd1, 0, 32'h0000_0100, 1'b1, 1'b1, 1'b0);
      push(2'd1, 1, 32'h0000_0104, 1'b1, 1'b1, 1'b1);
      send_req(2'd1, MEM_STRIDED, 16'h0003, 32'h0000_0100, 32'h4, 1'b0);
      wait_drain();

      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
